instr_encoder: RTL and testbench

Pipelined RV32I instruction encoder, the inverse of the core's main control decoder. It accepts instruction fields (class, register indices, funct bits, immediate) over a valid/ready handshake and packs them into 32-bit R/I/load/S/B-type words. Each word is buffered in a 2-entry output FIFO and presented with a word-aligned instruction-memory address. The block is used by the test and boot infrastructure to load programs into instruction memory before the pipeline is released.

---
 rtl/instr_encoder.sv | 169 ++++++++++++++++
 tb/tb_instr_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs R/I/load/S/B field bundles into 32-bit words through a 2-entry output FIFO.
// Optional macro ENC_CHECK_EN: reject illegal bundles and raise the sticky err flag.
module instr_encoder #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err
);

   function automatic logic [31:0] encode(
      input logic [2:0]  cls,
      input logic [2:0]  f3,
      input logic        f7b5,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [12:0] imm
   );
      logic [31:0] w;
      case (cls)
         3'd0:    w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
         3'd1:    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
         3'd2:    w = {imm[11:0], rs1, f3, rd, 7'b0000011};
         3'd3:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
         3'd4:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
         default: w = 32'h0000_0013;
      endcase
      return w;
   endfunction

`ifdef ENC_CHECK_EN
   function automatic logic is_bad(
      input logic [2:0]  cls,
      input logic [2:0]  f3,
      input logic        f7b5,
      input logic [12:0] imm
   );
      logic b;
      case (cls)
         3'd0:    b = f7b5 && (f3 != 3'b000) && (f3 != 3'b101);
         3'd1:    b = 1'b0;
         3'd2:    b = 1'b0;
         3'd3:    b = 1'b0;
         3'd4:    b = imm[0];
         default: b = 1'b1;
      endcase
      return b;
   endfunction
`endif

   logic [31:0]       head_q, head_d, tail_q, tail_d;
   logic [1:0]        count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              in_ready_q, in_ready_d;
   logic              accept_s, bad_s, push_s, pop_s;
   logic [31:0]       word_s;

   // Handshake qualification and combinational encode; clr suppresses both transfers.
   always_comb begin
      accept_s = in_valid && in_ready_q && !clr;
`ifdef ENC_CHECK_EN
      bad_s    = is_bad(in_class, in_funct3, in_funct7b5, in_imm);
`else
      bad_s    = 1'b0;
`endif
      push_s   = accept_s && !bad_s;
      pop_s    = (count_q != 2'd0) && out_ready && !clr;
      word_s   = encode(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm);
   end

   // FIFO next-state: head holds the presented word, tail the queued one.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      addr_d  = addr_q;
      if (clr) begin
         count_d = 2'd0;
         addr_d  = '0;
      end else begin
         if (pop_s) begin
            addr_d = addr_q + ADDR_W'(3'd4);
         end else begin
            addr_d = addr_q;
         end
         case ({push_s, pop_s})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_d = word_s;
               end else begin
                  tail_d = word_s;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = count_q - 2'd1;
            end
            // Push with pop only happens at count 1: the new word becomes the head.
            2'b11: begin
               head_d = word_s;
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
      in_ready_d = (count_d != 2'd2);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= 32'h0000_0000;
         tail_q     <= 32'h0000_0000;
         count_q    <= 2'd0;
         addr_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         in_ready_q <= in_ready_d;
      end
   end

`ifdef ENC_CHECK_EN
   logic err_q;

   // Sticky error: set by a rejected bundle, cleared only by reset or clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (clr) begin
         err_q <= 1'b0;
      end else if (accept_s && bad_s) begin
         err_q <= 1'b1;
      end else begin
         err_q <= err_q;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = (count_q != 2'd0);
   assign out_instr = head_q;
   assign out_addr  = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected {word, addr}, a negedge monitor pops on each output transfer.
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst, clr, in_valid, in_ready;
   logic [2:0]  in_class, in_funct3;
   logic        in_funct7b5;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [12:0] in_imm;
   logic        out_valid, out_ready;
   logic [31:0] out_instr;
   logic [9:0]  out_addr;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [41:0] sb[$];
   logic [9:0]  exp_addr;

   instr_encoder #(.ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output transfer is matched against the scoreboard head.
   always @(negedge clk) begin
      if (rst && !clr && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %h @%h expected none", out_instr, out_addr);
         end else begin
            logic [41:0] e;
            e = sb.pop_front();
            check("out_instr", out_instr, e[41:10]);
            check("out_addr", {22'd0, out_addr}, {22'd0, e[9:0]});
         end
      end
   end

   task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [12:0] imm, input logic [31:0] exp_word, input logic expect_out);
      int t;
      in_class = cls; in_funct3 = f3; in_funct7b5 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge clk);
      if (expect_out) begin
         sb.push_back({exp_word, exp_addr});
         exp_addr = exp_addr + 10'd4;
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || out_valid) && t < 50) begin
         @(posedge clk);
         #1 t++;
      end
      check("drained", {31'd0, out_valid}, 32'd0);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      sb.delete();
      exp_addr = 10'd0;
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_class = 3'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
      in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 13'd0;
      exp_addr = 10'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_addr", {22'd0, out_addr}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 check("ready_after_rst", {31'd0, in_ready}, 32'd1);

      // add / sub back to back
      out_ready = 1'b1;
      send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
      send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 13'd0, 32'h402081B3, 1'b1);
      // lw / sw / beq
      send(3'd2, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0, 13'd8, 32'h0080A283, 1'b1);
      send(3'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd5, 13'd12, 32'h0050A623, 1'b1);
      send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3, 1'b1);
      drain();

      // backpressure: third bundle waits for out_ready
      pulse_clr();
      out_ready = 1'b0;
      send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd1, 32'h00100093, 1'b1);
      send(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 13'd2, 32'h00200113, 1'b1);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("stall_instr", out_instr, 32'h00100093);
      check("stall_addr", {22'd0, out_addr}, 32'd0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      send(3'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 13'd3, 32'h00300193, 1'b1);
      drain();

      // clr while full
      out_ready = 1'b0;
      send(3'd1, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 13'd4, 32'h00400213, 1'b1);
      send(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 13'd5, 32'h00500293, 1'b1);
      pulse_clr();
      check("clr_out_valid", {31'd0, out_valid}, 32'd0);
      check("clr_in_ready", {31'd0, in_ready}, 32'd1);
      check("clr_out_addr", {22'd0, out_addr}, 32'd0);
      out_ready = 1'b1;
      send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
      drain();

      // illegal class then a valid add
      pulse_clr();
`ifdef ENC_CHECK_EN
      send(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0, 32'h0, 1'b0);
      send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
      drain();
      check("err_set", {31'd0, err}, 32'd1);
      pulse_clr();
      check("err_clr", {31'd0, err}, 32'd0);
`else
      send(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0, 32'h00000013, 1'b1);
      send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1);
      drain();
      check("err_zero", {31'd0, err}, 32'd0);
`endif

      // address wrap past 0x3FC
      pulse_clr();
      for (int i = 0; i < 260; i++) begin
         logic [11:0] iv;
         iv = 12'(i);
         send(3'd1, 3'd0, 1'b0, 5'(i), 5'd1, 5'd0, {1'b0, iv},
              {iv, 5'd1, 3'd0, 5'(i), 7'b0010011}, 1'b1);
      end
      drain();
      check("wrap_addr", {22'd0, out_addr}, {22'd0, 10'd16});

      // reset mid-stream drops buffered words
      out_ready = 1'b0;
      send(3'd1, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 13'd6, 32'h00600313, 1'b1);
      send(3'd1, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 13'd7, 32'h00700393, 1'b1);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_addr", {22'd0, out_addr}, 32'd0);
      sb.delete();
      exp_addr = 10'd0;
      @(negedge clk) rst = 1'b1;
      out_ready = 1'b1;
      send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3, 1'b1);
      drain();

      check("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
